dmm_mem_bridge: RTL and testbench
=================================

Name: dmm_mem_bridge

Overview:
- Downstream of the dynamic memory manager. Consumes its 256-bit dmm_unit request port (strobe/addr/rw/dataout/size/done/datain) and serialises each request into a sequence of 32-bit single-beat memory bus transfers.
- Handles allocator header/word traffic and atomic-unit traffic through the same port.
- Packs read beats back into the 256-bit return word and pulses done once per request.

Parameters:
- MAX_BYTES, 32, largest request in bytes; larger sizes are clamped to this.
- BEAT_BYTES, 4, bytes per bus beat. Fixed at 4; other values are unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- dmm_unit_strobe  in  1  request valid (level, held until done)
- dmm_unit_addr  in  32  byte address of first byte
- dmm_unit_rw  in  1  1=write, 0=read
- dmm_unit_dataout  in  256  write data, byte 0 at [255:248]
- dmm_unit_size  in  8  request length in bytes
- dmm_unit_done  out  1  one-cycle completion pulse
- dmm_unit_datain  out  256  read data, byte 0 at [255:248], valid with done
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned bus address
- mem_wdata  out  32  bus write word
- mem_wstrb  out  4  byte-lane enables (lane k = byte k of the word)
- mem_ack  in  1  beat accepted; for reads, mem_rdata is valid this cycle
- mem_rdata  in  32  bus read word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0, dmm_unit_datain=0, internal beat counter=0.
- Reset mid-transfer:
  - The transfer is abandoned and no done pulse is produced.
  - A mem_ack arriving after reset is ignored.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If strobe=1, capture addr, rw, dataout, size and go to XFER.
  - Effective size = min(size, MAX_BYTES).
  - beats = ceil(effective size / 4).
  - Capture clears the read assembly register to 0.
- Zero size (size==0): go straight from IDLE to DONE. No bus traffic; datain=0.
- XFER:
  - mem_req=1 continuously.
  - mem_addr = {addr[31:2],2'b00} + 4*i, where i is the beat index. addr[1:0] is ignored.
  - mem_we = rw.
  - mem_wdata = dataout[255-32i -: 32].
  - mem_wstrb = 4'b1111, except on a final partial beat with r = size mod 4 bytes: 4'b0001, 4'b0011 or 4'b0111 for r = 1, 2 or 3.
  - For reads mem_wstrb = 0, and mem_wdata is don't-care but driven 0.
  - On mem_ack:
    - Reads store mem_rdata into datain[255-32i -: 32]. Bytes beyond size in a partial beat are masked to 0.
    - i increments.
    - If the ack was for the last beat, go to DONE; otherwise stay in XFER with the next beat presented in the following cycle.
  - mem_req stays high across beats (back-to-back). The bus must not ack while mem_req=0.
- Address wrap: mem_addr wraps modulo 2^32; no error is flagged.
- DONE:
  - dmm_unit_done=1 for exactly one cycle, with dmm_unit_datain valid. Next state is IDLE.
  - datain holds its value until the next capture.
- Strobe rule: the requester drops strobe in the cycle after done. A strobe seen in IDLE is always a new request. Changes to strobe or request fields during XFER or DONE are ignored.
- Latency, with mem_ack asserted on the first cycle of every beat:
  - strobe sampled in cycle 0;
  - beats occupy cycles 1..N;
  - done in cycle N+1.
  - Each wait cycle on mem_ack adds one cycle.
- busy = (state != IDLE).

Test Plan:
- Single-word write: size=4, addr=0x70000010, rw=1, dataout[255:224]=0xDEADBEEF, ack immediate → one beat: mem_addr=0x70000010, wdata=0xDEADBEEF, wstrb=4'hF; done in cycle 2.
- Full-line read: size=32, addr=0x70000100, rdata=beat index+0x11110000 → addresses 0x70000100..0x7000011C; datain[255:224]=0x11110000 … datain[31:0]=0x11110007; done in cycle 9.
- Atomic-style read with stalls: size=8, mem_ack delayed 3 cycles per beat → two beats; done in cycle 1+2*4=9; datain[191:0]=0.
- Partial and clamped sizes:
  - size=6 write → beat 0 wstrb=4'hF, beat 1 wstrb=4'h3.
  - size=6 read with rdata=0xFFFFFFFF → datain[223:208]=0xFFFF, datain[207:192]=0.
  - size=40 → exactly 8 beats.
- Zero size and unaligned address:
  - size=0 → done in cycle 1, mem_req never asserted.
  - addr=0x70000003, size=4 → mem_addr=0x70000000.
- Reset mid-XFER: rst during beat 2 of 8 → next cycle mem_req=0, busy=0, no done; a new size=4 read afterwards completes normally.

Source files
------------

// File: rtl/dmm_mem_bridge_if.sv
// Bundles the dynamic-memory-manager request port and the 32-bit single-beat
// memory bus that dmm_mem_bridge sits between.
//   dmm_unit_* : 256-bit request/response port from the memory manager
//                (strobe/addr/rw/dataout/size in, done/datain out)
//   mem_*      : word bus (req/we/addr/wdata/wstrb out, ack/rdata in)
// Modports:
//   slave  : the bridge itself (serves requests, drives the word bus)
//   master : the environment (issues requests, answers the word bus)
interface dmm_mem_bridge_if;
  logic         dmm_unit_strobe;
  logic [31:0]  dmm_unit_addr;
  logic         dmm_unit_rw;
  logic [255:0] dmm_unit_dataout;
  logic [7:0]   dmm_unit_size;
  logic         dmm_unit_done;
  logic [255:0] dmm_unit_datain;

  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  modport slave (
    input  dmm_unit_strobe, dmm_unit_addr, dmm_unit_rw, dmm_unit_dataout, dmm_unit_size,
    output dmm_unit_done, dmm_unit_datain,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport master (
    output dmm_unit_strobe, dmm_unit_addr, dmm_unit_rw, dmm_unit_dataout, dmm_unit_size,
    input  dmm_unit_done, dmm_unit_datain,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmm_mem_bridge.sv
// Serialises one 256-bit memory-manager request into up to eight 32-bit
// single-beat bus transfers, assembles read beats back into the 256-bit
// return word and pulses done once per request.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : dmm_mem_bridge_if.slave (request port + word bus)
//   busy : high whenever the bridge is not idle
module dmm_mem_bridge #(
  parameter int MAX_BYTES  = 32,
  parameter int BEAT_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dmm_mem_bridge_if.slave       bus,
  output logic                  busy
);

  localparam logic [7:0] MAX_B  = 8'(MAX_BYTES);
  localparam logic [7:0] BEAT_B = 8'(BEAT_BYTES);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic                rw_q, rw_d;
  // Word 0 of these packed arrays is the most significant 32 bits, which is
  // where byte 0 of the request lives.
  logic [0:7][31:0]    wdata_q, wdata_d;
  logic [0:7][31:0]    rword_q, rword_d;
  logic [7:0]          beats_q, beats_d;
  logic [7:0]          beat_q, beat_d;
  logic [1:0]          rem_q, rem_d;

  logic [7:0]          size_eff;
  logic [7:0]          beats_req;
  logic                last_beat;
  logic [3:0]          part_strb;
  logic [31:0]         part_mask;

  always_comb begin
    size_eff  = (bus.dmm_unit_size > MAX_B) ? MAX_B : bus.dmm_unit_size;
    beats_req = (size_eff + BEAT_B - 8'd1) / BEAT_B;
    last_beat = (beat_q == beats_q - 8'd1);
    // Trailing partial beat: write strobes count up from lane 0, while the
    // read mask keeps the leading bytes, which sit in the upper bits.
    case (rem_q)
      2'd1:    begin part_strb = 4'b0001; part_mask = 32'hFF00_0000; end
      2'd2:    begin part_strb = 4'b0011; part_mask = 32'hFFFF_0000; end
      2'd3:    begin part_strb = 4'b0111; part_mask = 32'hFFFF_FF00; end
      default: begin part_strb = 4'b1111; part_mask = 32'hFFFF_FFFF; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    beats_d = beats_q;
    beat_d  = beat_q;
    rem_d   = rem_q;

    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = 32'd0;
    bus.mem_wdata     = 32'd0;
    bus.mem_wstrb     = 4'd0;
    bus.dmm_unit_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.dmm_unit_strobe) begin
          addr_d  = bus.dmm_unit_addr;
          rw_d    = bus.dmm_unit_rw;
          wdata_d = bus.dmm_unit_dataout;
          rword_d = '0;
          beats_d = beats_req;
          beat_d  = 8'd0;
          rem_d   = size_eff[1:0];
          state_d = (size_eff == 8'd0) ? DONE : XFER;
        end
      end

      XFER: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = rw_q;
        // The offset is word-aligned, so clearing the low bits after the add
        // gives the same result as aligning the base first (wraps mod 2^32).
        bus.mem_addr = (addr_q + {22'd0, beat_q, 2'b00}) & 32'hFFFF_FFFC;
        if (rw_q) begin
          bus.mem_wdata = wdata_q[beat_q[2:0]];
          bus.mem_wstrb = last_beat ? part_strb : 4'b1111;
        end
        if (bus.mem_ack) begin
          if (!rw_q) begin
            rword_d[beat_q[2:0]] = bus.mem_rdata & (last_beat ? part_mask : 32'hFFFF_FFFF);
          end
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        bus.dmm_unit_done = 1'b1;
        state_d           = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.dmm_unit_datain = rword_q;
  assign busy                = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rword_q <= '0;
      beats_q <= 8'd0;
      beat_q  <= 8'd0;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_dmm_mem_bridge.sv
module tb_dmm_mem_bridge;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  dmm_mem_bridge_if bus ();

  dmm_mem_bridge #(
    .MAX_BYTES (32),
    .BEAT_BYTES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } beat_t;

  beat_t        exp_beats[$];
  logic [255:0] exp_datain[$];
  int           exp_done_cyc[$];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: builds the expected beat list, return word and done
  // cycle from the request, bytewise, and pushes them onto the scoreboard.
  task automatic push_expect(input logic [31:0] a, input logic rw, input logic [255:0] d,
                             input int sz, input int dly, input logic [31:0] rbase);
    int           eff;
    int           nb;
    beat_t        b;
    logic [255:0] din;
    logic [31:0]  word;
    eff = (sz > 32) ? 32 : sz;
    nb  = (eff + 3) / 4;
    din = '0;
    for (int i = 0; i < nb; i++) begin
      b.addr  = (a & 32'hFFFF_FFFC) + 32'(4 * i);
      b.we    = rw;
      b.wdata = rw ? d[255 - 32*i -: 32] : 32'd0;
      b.wstrb = 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (rw && (4*i + k < eff)) b.wstrb[k] = 1'b1;
      end
      exp_beats.push_back(b);
    end
    if (!rw) begin
      for (int by = 0; by < eff; by++) begin
        word = rbase ^ 32'(by / 4);
        din[255 - 8*by -: 8] = word[31 - 8*(by % 4) -: 8];
      end
    end
    exp_datain.push_back(din);
    exp_done_cyc.push_back(1 + nb * (dly + 1));
  endtask

  // Issues one request starting at a negedge (cycle 0), answers the bus with
  // dly wait cycles per beat, and scores beats and completion.
  task automatic run_req(input string tag, input logic [31:0] a, input logic rw,
                         input logic [255:0] d, input int sz, input int dly,
                         input logic [31:0] rbase);
    int    n;
    int    waitc;
    int    bidx;
    bit    new_beat;
    bit    finished;
    beat_t e;
    push_expect(a, rw, d, sz, dly, rbase);
    bus.dmm_unit_strobe  = 1'b1;
    bus.dmm_unit_addr    = a;
    bus.dmm_unit_rw      = rw;
    bus.dmm_unit_dataout = d;
    bus.dmm_unit_size    = 8'(sz);
    n        = 0;
    waitc    = 0;
    bidx     = 0;
    new_beat = 1'b1;
    finished = 1'b0;
    while (!finished && n < 200) begin
      @(negedge clk);
      n++;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'd0;
      if (bus.dmm_unit_done) begin
        chk({tag, " done_cycle"}, 256'(n), 256'(exp_done_cyc.pop_front()));
        chk({tag, " datain"}, bus.dmm_unit_datain, exp_datain.pop_front());
        chk({tag, " beats_left"}, 256'(exp_beats.size()), 256'(0));
        bus.dmm_unit_strobe = 1'b0;
        finished = 1'b1;
      end else if (bus.mem_req) begin
        if (new_beat) begin
          if (exp_beats.size() == 0) begin
            chk({tag, " unexpected_beat_addr"}, 256'(bus.mem_addr), 256'('1));
          end else begin
            e = exp_beats.pop_front();
            $display("%s beat%0d addr=%08h we=%0b wdata=%08h wstrb=%01h", tag, bidx,
                     bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.mem_wstrb);
            chk({tag, " mem_addr"},  256'(bus.mem_addr),  256'(e.addr));
            chk({tag, " mem_we"},    256'(bus.mem_we),    256'(e.we));
            chk({tag, " mem_wdata"}, 256'(bus.mem_wdata), 256'(e.wdata));
            chk({tag, " mem_wstrb"}, 256'(bus.mem_wstrb), 256'(e.wstrb));
            chk({tag, " busy"},      256'(busy),          256'(1));
          end
          new_beat = 1'b0;
          waitc    = 0;
        end
        if (waitc == dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rbase ^ 32'(bidx);
          bidx++;
          new_beat = 1'b1;
        end else begin
          waitc++;
        end
      end
    end
    if (!finished) begin
      chk({tag, " done_seen"}, 256'(finished), 256'(1));
      exp_beats.delete();
      exp_datain.delete();
      exp_done_cyc.delete();
      bus.dmm_unit_strobe = 1'b0;
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk({tag, " done_one_cycle"}, 256'(bus.dmm_unit_done), 256'(0));
    chk({tag, " idle_after"},     256'(busy),              256'(0));
    $display("%s size=%0d rw=%0b cycles=%0d datain=%064h", tag, sz, rw, n, bus.dmm_unit_datain);
  endtask

  logic [255:0] wpat;
  int           cnt;
  bit           hit;

  initial begin
    rst                  = 1'b1;
    bus.dmm_unit_strobe  = 1'b0;
    bus.dmm_unit_addr    = 32'd0;
    bus.dmm_unit_rw      = 1'b0;
    bus.dmm_unit_dataout = '0;
    bus.dmm_unit_size    = 8'd0;
    bus.mem_ack          = 1'b0;
    bus.mem_rdata        = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset mem_req",   256'(bus.mem_req),       256'(0));
    chk("reset mem_we",    256'(bus.mem_we),        256'(0));
    chk("reset mem_addr",  256'(bus.mem_addr),      256'(0));
    chk("reset mem_wdata", 256'(bus.mem_wdata),     256'(0));
    chk("reset mem_wstrb", 256'(bus.mem_wstrb),     256'(0));
    chk("reset done",      256'(bus.dmm_unit_done), 256'(0));
    chk("reset datain",    bus.dmm_unit_datain,     256'(0));
    chk("reset busy",      256'(busy),              256'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) wpat[255 - 32*i -: 32] = $urandom();

    run_req("wr4",     32'h7000_0010, 1'b1, {32'hDEAD_BEEF, wpat[223:0]}, 4, 0, 32'h0);
    run_req("rd32",    32'h7000_0100, 1'b0, wpat, 32, 0, 32'h1111_0000);
    run_req("rd8_stall", 32'h7000_0200, 1'b0, wpat, 8, 3, 32'h2222_0000);
    run_req("wr6",     32'h7000_0300, 1'b1, wpat, 6, 0, 32'h0);
    run_req("rd6",     32'h7000_0300, 1'b0, wpat, 6, 1, 32'hFFFF_FFFF);
    run_req("wr40",    32'h7000_0400, 1'b1, wpat, 40, 0, 32'h0);
    run_req("rd0",     32'h7000_0500, 1'b0, wpat, 0, 0, 32'h3333_0000);
    run_req("rd_unal", 32'h7000_0003, 1'b0, wpat, 4, 0, 32'h4444_0000);
    run_req("wr_wrap", 32'hFFFF_FFF8, 1'b1, wpat, 16, 2, 32'h0);
    run_req("rd7",     32'h7000_0600, 1'b0, wpat, 7, 0, 32'h5555_AAAA);

    // Reset in the middle of a 32-byte read, while beat 2 is on the bus.
    bus.dmm_unit_strobe = 1'b1;
    bus.dmm_unit_addr   = 32'h7000_0700;
    bus.dmm_unit_rw     = 1'b0;
    bus.dmm_unit_size   = 8'd32;
    cnt = 0;
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (cnt == 2) begin
          rst                 = 1'b1;
          bus.dmm_unit_strobe = 1'b0;
          hit                 = 1'b1;
        end else begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 32'hCAFE_0000 ^ 32'(cnt);
          cnt++;
        end
      end
    end
    chk("rst reached beat2", 256'(hit), 256'(1));
    @(negedge clk);
    rst = 1'b0;
    chk("rst mem_req", 256'(bus.mem_req),       256'(0));
    chk("rst busy",    256'(busy),              256'(0));
    chk("rst done",    256'(bus.dmm_unit_done), 256'(0));
    chk("rst datain",  bus.dmm_unit_datain,     256'(0));
    $display("rst_mid beats_before_reset=%0d busy=%0b", cnt, busy);
    // A stray ack after reset must not restart anything.
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    for (int n = 0; n < 4; n++) begin
      chk("post_rst no_done", 256'(bus.dmm_unit_done), 256'(0));
      chk("post_rst no_req",  256'(bus.mem_req),       256'(0));
      @(negedge clk);
    end
    chk("post_rst datain", bus.dmm_unit_datain, 256'(0));

    run_req("rd4_after_rst", 32'h7000_0800, 1'b0, wpat, 4, 0, 32'hA5A5_0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
